// File: rtl/ins_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory, LSB first at BaseAddr + 4*k.
// Optional INS_MEM_LOADER_CHECKSUM_EN adds a running word checksum compared against ExpectSum.
module ins_mem_loader #(
  parameter int MEM_BYTES = 10000,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [31:0]      i_base_addr,
  input  logic [CNT_W-1:0] i_word_count,
  input  logic [31:0]      i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_mem_we,
  output logic [31:0]      o_mem_addr,
  output logic [7:0]       o_mem_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_addr_err,
`ifdef INS_MEM_LOADER_CHECKSUM_EN
  input  logic [31:0]      i_expect_sum,
  output logic [31:0]      o_checksum,
  output logic             o_sum_err,
`endif
  output logic [CNT_W-1:0] o_words_loaded
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_WORD, S_WRITE, S_FINISH} state_t;

  localparam logic [32:0] LAST_BYTE = 33'(MEM_BYTES - 1);

  state_t           r_state, w_next;
  logic [31:0]      r_ptr;
  logic [31:0]      r_word;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_count;
  logic             w_ovf, w_start, w_accept, w_abort, w_word_done;

  // 33-bit compare so a pointer near 0xFFFFFFFF cannot wrap past the check
  assign w_ovf = ({1'b0, r_ptr} + 33'd3) > LAST_BYTE;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_in_ready  = 1'b0;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    w_word_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_start = 1'b1;
          w_next  = (i_word_count != '0) ? S_WAIT_WORD : S_FINISH;
        end
      end
      S_WAIT_WORD: begin
        if (w_ovf) begin
          w_abort = 1'b1;
          w_next  = S_FINISH;
        end else begin
          o_in_ready = 1'b1;
          if (i_in_valid) begin
            w_accept = 1'b1;
            w_next   = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // r_idx wraps to 0 while the fourth byte is on the bus
        if (r_idx == 2'd0) begin
          w_word_done = 1'b1;
          w_next = (({1'b0, o_words_loaded} + (CNT_W+1)'(1)) < {1'b0, r_count})
                   ? S_WAIT_WORD : S_FINISH;
        end
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

`ifdef INS_MEM_LOADER_CHECKSUM_EN
  logic [31:0] r_expect;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_checksum <= '0;
      o_sum_err  <= 1'b0;
      r_expect   <= '0;
    end else begin
      if (w_start) begin
        o_checksum <= '0;
        o_sum_err  <= 1'b0;
        r_expect   <= i_expect_sum;
      end
      if (w_accept) o_checksum <= o_checksum + i_in_data;
      if (r_state == S_FINISH && !o_addr_err && o_checksum != r_expect)
        o_sum_err <= 1'b1;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr          <= '0;
      r_word         <= '0;
      r_idx          <= '0;
      r_count        <= '0;
      o_mem_we       <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_data     <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_addr_err     <= 1'b0;
      o_words_loaded <= '0;
    end else begin
      o_done <= 1'b0;
      if (w_start) begin
        r_ptr          <= i_base_addr;
        r_count        <= i_word_count;
        o_addr_err     <= 1'b0;
        o_words_loaded <= '0;
        o_busy         <= 1'b1;
      end
      if (w_abort) o_addr_err <= 1'b1;
      if (w_accept) begin
        r_word     <= i_in_data;
        r_idx      <= 2'd1;
        o_mem_we   <= 1'b1;
        o_mem_addr <= r_ptr;
        o_mem_data <= i_in_data[7:0];
      end
      if (r_state == S_WRITE) begin
        if (w_word_done) begin
          o_mem_we       <= 1'b0;
          o_words_loaded <= o_words_loaded + 1'b1;
          r_ptr          <= r_ptr + 32'd4;
        end else begin
          o_mem_addr <= r_ptr + {30'd0, r_idx};
          o_mem_data <= r_word[{r_idx, 3'b000} +: 8];
          r_idx      <= r_idx + 2'd1;
        end
      end
      if (r_state == S_FINISH) begin
        o_busy <= 1'b0;
        o_done <= 1'b1;
      end
    end
  end

endmodule
